// File: rtl/xocc_chan_hub.sv
// CPU-to-accelerator channel hub: per-channel command assembly and FIFO toward the
// accelerator, a response FIFO back to the CPU, sticky error flags and a registered interrupt.
module xocc_chan_hub #(
    parameter int NUM_CH = 2,
    parameter int CMD_W  = 96,
    parameter int DEPTH  = 4
) (
    input  logic                    i_pad_clk,
    input  logic                    i_pad_rst_b,
    input  logic                    cpu_wr_en,
    input  logic [3:0]              cpu_ch,
    input  logic [31:0]             cpu_wdata,
    input  logic                    cpu_rd_en,
    output logic [31:0]             cpu_rdata,
    output logic [NUM_CH-1:0]       cpu_cmd_full,
    output logic [NUM_CH-1:0]       cpu_rsp_empty,
    output logic [2*NUM_CH-1:0]     cpu_err,
    input  logic                    cpu_err_clr,
    input  logic [NUM_CH-1:0]       irq_en,
    output logic                    irq,
    output logic [NUM_CH*CMD_W-1:0] xocc_cmd_buffer,
    output logic [NUM_CH-1:0]       xocc_cmd_empty,
    input  logic [NUM_CH-1:0]       xocc_cmd_rd_en,
    input  logic [NUM_CH*32-1:0]    xocc_rsp_buffer,
    input  logic [NUM_CH-1:0]       xocc_rsp_wr_en,
    output logic [NUM_CH-1:0]       xocc_rsp_full
);
    localparam int BEATS = CMD_W / 32;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic                ch_valid;
    logic [2*NUM_CH-1:0] err_set;
    logic [2*NUM_CH-1:0] err_q;
    logic                irq_q;
    logic [31:0]         rsp_head [NUM_CH];

    assign ch_valid = int'(cpu_ch) < NUM_CH;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic              sel;
        logic [BW-1:0]     beat_q, beat_d;
        logic [CMD_W-1:0]  asm_q, asm_d;
        logic [CMD_W-1:0]  cmd_mem [DEPTH];
        logic [PW-1:0]     cwp_q, crp_q, crp_d;
        logic [CW-1:0]     ccnt_q, ccnt_d;
        logic [CMD_W-1:0]  head_q, head_d;
        logic              cmd_push, cmd_push_ok, cmd_pop_ok;
        logic [31:0]       rsp_mem [DEPTH];
        logic [PW-1:0]     rwp_q, rrp_q;
        logic [CW-1:0]     rcnt_q;
        logic              rsp_pop, rsp_push_ok, rsp_pop_ok;

        assign sel = ch_valid && (cpu_ch == 4'(ch));

        always_comb begin
            beat_d   = beat_q;
            asm_d    = asm_q;
            cmd_push = 1'b0;
            if (cpu_wr_en && sel) begin
                asm_d[32*int'(beat_q) +: 32] = cpu_wdata;
                if (beat_q == LAST_BEAT) begin
                    beat_d   = '0;
                    cmd_push = 1'b1;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
        end

        assign cmd_push_ok    = cmd_push && (ccnt_q != FULL_CNT);
        assign cmd_pop_ok     = xocc_cmd_rd_en[ch] && (ccnt_q != '0);
        assign err_set[ch]    = cmd_push && (ccnt_q == FULL_CNT);

        // Registered show-ahead head: takes the incoming entry when no older entry survives.
        always_comb begin
            crp_d  = cmd_pop_ok ? crp_q + PW'(1) : crp_q;
            ccnt_d = ccnt_q + CW'(cmd_push_ok) - CW'(cmd_pop_ok);
            head_d = head_q;
            if (ccnt_d != '0) begin
                head_d = (ccnt_q == CW'(cmd_pop_ok)) ? asm_d : cmd_mem[crp_d];
            end
        end

        assign rsp_pop     = cpu_rd_en && sel;
        assign rsp_push_ok = xocc_rsp_wr_en[ch] && (rcnt_q != FULL_CNT);
        assign rsp_pop_ok  = rsp_pop && (rcnt_q != '0);
        assign err_set[NUM_CH+ch] = (xocc_rsp_wr_en[ch] && (rcnt_q == FULL_CNT)) ||
                                    (rsp_pop && (rcnt_q == '0));

        always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
            if (!i_pad_rst_b) begin
                beat_q <= '0;
                cwp_q  <= '0;
                crp_q  <= '0;
                ccnt_q <= '0;
                head_q <= '0;
                rwp_q  <= '0;
                rrp_q  <= '0;
                rcnt_q <= '0;
            end else begin
                beat_q <= beat_d;
                cwp_q  <= cmd_push_ok ? cwp_q + PW'(1) : cwp_q;
                crp_q  <= crp_d;
                ccnt_q <= ccnt_d;
                head_q <= head_d;
                rwp_q  <= rsp_push_ok ? rwp_q + PW'(1) : rwp_q;
                rrp_q  <= rsp_pop_ok ? rrp_q + PW'(1) : rrp_q;
                rcnt_q <= rcnt_q + CW'(rsp_push_ok) - CW'(rsp_pop_ok);
            end
        end

        // Storage is never read before being written, so it carries no reset.
        always_ff @(posedge i_pad_clk) begin
            asm_q <= asm_d;
            if (cmd_push_ok) cmd_mem[cwp_q] <= asm_d;
            if (rsp_push_ok) rsp_mem[rwp_q] <= xocc_rsp_buffer[ch*32 +: 32];
        end

        assign rsp_head[ch]                       = (rcnt_q != '0) ? rsp_mem[rrp_q] : '0;
        assign xocc_cmd_buffer[ch*CMD_W +: CMD_W] = head_q;
        assign xocc_cmd_empty[ch]                 = (ccnt_q == '0);
        assign cpu_cmd_full[ch]                   = (ccnt_q == FULL_CNT);
        assign cpu_rsp_empty[ch]                  = (rcnt_q == '0);
        assign xocc_rsp_full[ch]                  = (rcnt_q == FULL_CNT);
    end

    always_comb begin
        cpu_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid && (int'(cpu_ch) == i)) cpu_rdata = rsp_head[i];
        end
    end

    always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
        if (!i_pad_rst_b) begin
            err_q <= '0;
            irq_q <= 1'b0;
        end else begin
            err_q <= cpu_err_clr ? '0 : (err_q | err_set);
            irq_q <= |(irq_en & ~cpu_rsp_empty);
        end
    end

    assign cpu_err = err_q;
    assign irq     = irq_q;
endmodule

// File: doc/xocc_chan_hub.md
XOCC_CHAN_HUB -- requirements
Module: xocc_chan_hub

Interface
REQ-001 Parameter NUM_CH, default 2: number of XOCC channels, legal 1..16.
REQ-002 Parameter CMD_W, default 96: command entry width, a multiple of 32, legal 32..256; BEATS = CMD_W/32.
REQ-003 Parameter DEPTH, default 4: entries per FIFO, a power of 2, legal 2..64.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_pad_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_pad_rst_b  in  1  asynchronous, active-low reset.
REQ-007 cpu_wr_en  in  1  push one 32-bit command word into channel cpu_ch.
REQ-008 cpu_ch  in  4  channel select for cpu_wr_en and cpu_rd_en; values >= NUM_CH are ignored.
REQ-009 cpu_wdata  in  32  command word.
REQ-010 cpu_rd_en  in  1  pop one response from channel cpu_ch.
REQ-011 cpu_rdata  out  32  head of the response FIFO of cpu_ch, combinational; 0 when that FIFO is empty.
REQ-012 cpu_cmd_full  out  NUM_CH  command FIFO full, per channel.
REQ-013 cpu_rsp_empty  out  NUM_CH  response FIFO empty, per channel.
REQ-014 cpu_err  out  2*NUM_CH  sticky flags: [ch] = command overflow, [NUM_CH+ch] = response overflow or underflow.
REQ-015 cpu_err_clr  in  1  clears all cpu_err bits.
REQ-016 irq_en  in  NUM_CH  per-channel interrupt enable.
REQ-017 irq  out  1  registered interrupt.
REQ-018 xocc_cmd_buffer  out  NUM_CH*CMD_W  head command entry per channel, show-ahead; channel ch occupies slice [ch*CMD_W +: CMD_W].
REQ-019 xocc_cmd_empty  out  NUM_CH  command FIFO empty.
REQ-020 xocc_cmd_rd_en  in  NUM_CH  accelerator pops the head command.
REQ-021 xocc_rsp_buffer  in  NUM_CH*32  response word per channel.
REQ-022 xocc_rsp_wr_en  in  NUM_CH  accelerator pushes a response word.
REQ-023 xocc_rsp_full  out  NUM_CH  response FIFO full.

Function
REQ-024 Each channel SHALL keep a beat counter (0..BEATS-1) and an assembly register; each cpu_wr_en writes cpu_wdata into bits [32*beat +: 32] and increments the counter.
REQ-025 On the write of beat BEATS-1, the channel SHALL push the assembled entry (including the current word) into its command FIFO and reset the counter to 0.
REQ-026 If the command FIFO is full at that edge, the entry SHALL be dropped, cpu_err[ch] set, and the counter still reset to 0.
REQ-027 Full and empty SHALL be evaluated from the state before the edge; a push while full is dropped even if a pop occurs in the same cycle.
REQ-028 A pop while empty SHALL be ignored, so empty with push+pop in the same cycle results in one entry stored.
REQ-029 Push and pop in the same cycle while the FIFO is neither full nor empty SHALL leave the count unchanged.
REQ-030 An xocc_cmd_rd_en while empty SHALL be ignored with no error; the head slice of xocc_cmd_buffer holds its last value when empty.
REQ-031 xocc_rsp_wr_en while the response FIFO is full SHALL drop the word and set cpu_err[NUM_CH+ch].
REQ-032 cpu_rd_en while the response FIFO is empty SHALL return 0 and set cpu_err[NUM_CH+ch].
REQ-033 FIFO read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be $clog2(DEPTH)+1 bits.
REQ-034 Data written SHALL be visible at the FIFO head on the cycle after the push (one-cycle latency).
REQ-035 irq SHALL be registered as the OR over ch of (irq_en[ch] & ~cpu_rsp_empty[ch]), one cycle after the condition.
REQ-036 cpu_err_clr SHALL win over a simultaneous set event in the same cycle.
REQ-037 Writes and reads to cpu_ch >= NUM_CH SHALL change no state.

Reset
REQ-038 On reset assertion all FIFOs SHALL become empty: cpu_rsp_empty and xocc_cmd_empty all ones, full flags 0.
REQ-039 On reset assertion beat counters, cpu_err, and irq SHALL be 0, and xocc_cmd_buffer SHALL be 0.
REQ-040 Reset asserted mid-assembly or mid-transfer SHALL discard partial entries and all queued data.

Verification (NUM_CH=2, CMD_W=96, DEPTH=4)
REQ-041 Write 0x11, 0x22, 0x33 to ch0 -> the next cycle xocc_cmd_empty[0]=0 and xocc_cmd_buffer[95:0]=0x00000033_00000022_00000011.
REQ-042 Push 5 full commands to ch1 with no pops -> cpu_cmd_full[1]=1 after the 4th, the 5th is dropped, cpu_err[1]=1, and 4 pops return entries 1..4 in order.
REQ-043 With irq_en=2'b01, xocc_rsp_wr_en[0] with 0xCAFE -> irq=1 one cycle after cpu_rsp_empty[0]=0; cpu_rd_en on ch0 returns 0xCAFE, then irq=0.
REQ-044 cpu_rd_en on empty ch1 -> cpu_rdata=0 and cpu_err[3]=1; cpu_err_clr together with a new underflow -> cpu_err[3]=0.
REQ-045 Response FIFO at count 2 with push and pop in the same cycle for 10 cycles -> count stays 2, the pointers wrap, and data order is preserved.
REQ-046 Reset asserted after 2 of 3 beats on ch0 -> after release, 3 new words produce exactly one entry made of the new words only.
